// File: rtl/uart_tx_ctrl.sv
// Frame sequencer for the UART TX bit-select mux: latches {stop, data, start} and
// walks mux_slc across the frame at the baud rate so the mux output is the TX line.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FRAME_BITS   = 10,
    parameter int SLC_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic [FRAME_BITS-1:0] frame,
    output logic [SLC_W-1:0]      mux_slc
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [SLC_W-1:0]      SLC_LAST   = SLC_W'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] FRAME_IDLE = '1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] baud_cnt;

    // An all-ones frame keeps the line high whatever the select, so idle needs no mux gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frame    <= FRAME_IDLE;
            mux_slc  <= SLC_LAST;
            baud_cnt <= '0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        frame    <= FRAME_BITS'({1'b1, tx_data, 1'b0});
                        mux_slc  <= '0;
                        baud_cnt <= '0;
                        tx_ready <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (mux_slc < SLC_LAST) begin
                            mux_slc <= mux_slc + SLC_W'(1);
                        end else begin
                            state    <= IDLE;
                            frame    <= FRAME_IDLE;
                            mux_slc  <= SLC_LAST;
                            tx_ready <= 1'b1;
                            tx_done  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    frame    <= FRAME_IDLE;
                    mux_slc  <= SLC_LAST;
                    baud_cnt <= '0;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (4 and 1 clocks per bit) checked every cycle
// against a timeline model derived from the accept edge of each frame.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       start_v [2];
    logic [7:0] data_v  [2];
    logic       ready_v [2];
    logic       done_v  [2];
    logic [9:0] frame_v [2];
    logic [3:0] slc_v   [2];

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .FRAME_BITS(10), .SLC_W(4)) dut_n4 (
        .clk(clk), .rst(rst_v[0]), .tx_start(start_v[0]), .tx_data(data_v[0]),
        .tx_ready(ready_v[0]), .tx_done(done_v[0]), .frame(frame_v[0]), .mux_slc(slc_v[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(1), .FRAME_BITS(10), .SLC_W(4)) dut_n1 (
        .clk(clk), .rst(rst_v[1]), .tx_start(start_v[1]), .tx_data(data_v[1]),
        .tx_ready(ready_v[1]), .tx_done(done_v[1]), .frame(frame_v[1]), .mux_slc(slc_v[1])
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    longint     edge_n   = 0;

    // Model: a frame is fully described by the edge it was accepted on and its bits.
    int         bit_clks [2] = '{4, 1};
    bit         valid    [2] = '{1'b0, 1'b0};
    longint     acc_edge [2];
    logic [9:0] exp_frm  [2];
    bit         armed    [2] = '{1'b0, 1'b0};

    int         done_cnt  [2];
    longint     done_edge [2];
    longint     prev_done [2];

    task automatic check(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s dut%0d edge %0d: observed %0h, required %0h", tag, i, edge_n, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic r, input logic s, input logic [7:0] d);
        rst_v[i]   = r;
        start_v[i] = s;
        data_v[i]  = d;
    endtask

    function automatic bit model_busy(input int i, input longint at_edge);
        return valid[i] && (at_edge - acc_edge[i]) < 10 * bit_clks[i];
    endfunction

    task automatic modelEdge(input int i);
        bit was_busy;
        was_busy = model_busy(i, edge_n - 1);
        if (rst_v[i]) begin
            valid[i] = 1'b0;
            armed[i] = 1'b1;
        end else if (!was_busy && start_v[i]) begin
            valid[i]    = 1'b1;
            acc_edge[i] = edge_n;
            exp_frm[i]  = {1'b1, data_v[i], 1'b0};
        end
    endtask

    task automatic checkOutput(input int i);
        longint     d;
        bit         busy;
        int         k;
        logic [9:0] f;
        logic       obs_line;
        if (!armed[i]) return;
        d    = edge_n - acc_edge[i];
        busy = model_busy(i, edge_n);
        k    = busy ? int'(d / bit_clks[i]) : 9;
        f    = busy ? exp_frm[i] : 10'h3FF;
        obs_line = (slc_v[i] < 4'd10) ? frame_v[i][slc_v[i]] : 1'bx;
        check("line",    i, {15'd0, obs_line},    {15'd0, f[k]});
        check("tx_ready", i, {15'd0, ready_v[i]}, {15'd0, !busy});
        check("tx_done", i, {15'd0, done_v[i]},   {15'd0, valid[i] && d == 10 * bit_clks[i]});
        check("mux_slc", i, {12'd0, slc_v[i]},    16'(k));
        check("frame",   i, {6'd0, frame_v[i]},   {6'd0, f});
        if (done_v[i] === 1'b1) begin
            done_cnt[i]++;
            prev_done[i] = done_edge[i];
            done_edge[i] = edge_n;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) modelEdge(i);
        #1;
        for (int i = 0; i < 2; i++) checkOutput(i);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i]  = 0;
            done_edge[i] = 0;
            prev_done[i] = 0;
        end
    endtask

    initial begin
        applyStimulus(0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 8'h00);
        run(2);
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 8'h00);
        run(2);

        $display("[TB] single 8'hA5 frame, N=4");
        clear_counts();
        applyStimulus(0, 1'b0, 1'b1, 8'hA5);
        step();
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(45);
        check("done_count_a5", 0, 16'(done_cnt[0]), 16'd1);

        $display("[TB] start during frame is ignored");
        clear_counts();
        applyStimulus(0, 1'b0, 1'b1, 8'hA5);
        step();
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(9);
        applyStimulus(0, 1'b0, 1'b1, 8'h3C);
        step();
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(40);
        check("done_count_ignored", 0, 16'(done_cnt[0]), 16'd1);

        $display("[TB] back-to-back with tx_start held");
        clear_counts();
        applyStimulus(0, 1'b0, 1'b1, 8'h00);
        step();
        applyStimulus(0, 1'b0, 1'b1, 8'hFF);
        run(50);
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(40);
        check("done_count_b2b", 0, 16'(done_cnt[0]), 16'd2);
        check("done_gap_b2b", 0, 16'(done_edge[0] - prev_done[0]), 16'd41);

        $display("[TB] reset mid-frame, then 8'h81");
        clear_counts();
        applyStimulus(0, 1'b0, 1'b1, 8'hA5);
        step();
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(14);
        applyStimulus(0, 1'b1, 1'b0, 8'h00);
        step();
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(30);
        check("done_count_abort", 0, 16'(done_cnt[0]), 16'd0);
        applyStimulus(0, 1'b0, 1'b1, 8'h81);
        step();
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        run(44);
        check("done_count_81", 0, 16'(done_cnt[0]), 16'd1);

        $display("[TB] one clock per bit, 8'h01");
        clear_counts();
        applyStimulus(1, 1'b0, 1'b1, 8'h01);
        step();
        applyStimulus(1, 1'b0, 1'b0, 8'h00);
        run(13);
        check("done_count_n1", 1, 16'(done_cnt[1]), 16'd1);
        check("done_edge_n1", 1, 16'(done_edge[1] - (edge_n - 13)), 16'd10);

        $display("[TB] tx_data churn after accept of 8'h5A");
        applyStimulus(0, 1'b0, 1'b1, 8'h5A);
        step();
        for (int c = 0; c < 42; c++) begin
            applyStimulus(0, 1'b0, 1'b0, 8'($urandom));
            step();
        end

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++)
                applyStimulus(i, ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), 8'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
